mux_operand_loader: RTL

- Operand front end that sits directly upstream of the 4-bit 2:1 mux stage.
- Debounces and synchronizes the on-board push buttons, and captures two 4-bit operands from the switches into holding registers on key presses.
- Maintains a toggled select bit; x_out, y_out and sel_out feed the mux X, Y and S inputs.
- Operands are held stable while the switches change, so the mux output is deterministic and observable on LEDR.

---
 rtl/mux_operand_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mux_operand_loader.sv
// rtl/mux_operand_loader.sv - debounced key front end holding X/Y operands and select for the 2:1 mux stage
// One debounce channel per key; the holding registers only change on debounced press events.

module mux_operand_loader_key #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      count   <= '0;
    end else begin
      sync    <= {sync[0], key_n};
      level_d <= level;
      if (sync[1] == level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync[1];
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Only the 1->0 transition of the debounced level is an event; releases are silent.
  assign press = level_d & ~level;
endmodule

module mux_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_x_n,
  input  logic             load_y_n,
  input  logic             sel_toggle_n,
  input  logic             clear_n,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             sel_out,
  output logic             x_valid,
  output logic             y_valid,
  output logic             ready
);
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    Y_ONLY = 2'b01,
    X_ONLY = 2'b10,
    BOTH   = 2'b11
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] x_next, y_next;
  logic             sel_next;
  logic [WIDTH-1:0] data_s1, data_s2;
  logic             ev_load_x, ev_load_y, ev_sel, ev_clear;

  mux_operand_loader_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_x (
    .clk(CLOCK_50), .resetn(resetn), .key_n(load_x_n), .press(ev_load_x)
  );
  mux_operand_loader_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_y (
    .clk(CLOCK_50), .resetn(resetn), .key_n(load_y_n), .press(ev_load_y)
  );
  mux_operand_loader_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel (
    .clk(CLOCK_50), .resetn(resetn), .key_n(sel_toggle_n), .press(ev_sel)
  );
  mux_operand_loader_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk(CLOCK_50), .resetn(resetn), .key_n(clear_n), .press(ev_clear)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      data_s1 <= '0;
      data_s2 <= '0;
      state   <= EMPTY;
      x_out   <= '0;
      y_out   <= '0;
      sel_out <= 1'b0;
    end else begin
      data_s1 <= data_in;
      data_s2 <= data_s1;
      state   <= state_next;
      x_out   <= x_next;
      y_out   <= y_next;
      sel_out <= sel_next;
    end
  end

  // Clear wins outright; otherwise loads and toggle combine freely in one cycle.
  always_comb begin
    state_next = state;
    x_next     = x_out;
    y_next     = y_out;
    sel_next   = sel_out;
    if (ev_clear) begin
      state_next = EMPTY;
      x_next     = '0;
      y_next     = '0;
      sel_next   = 1'b0;
    end else begin
      if (ev_load_x) x_next = data_s2;
      if (ev_load_y) y_next = data_s2;
      if (ev_sel)    sel_next = ~sel_out;
      state_next = state_t'({state[1] | ev_load_x, state[0] | ev_load_y});
    end
  end

  assign x_valid = state[1];
  assign y_valid = state[0];
  assign ready   = (state == BOTH);
endmodule
